// File: rtl/sns_pkg.sv
// ============================================================================
// sns_pkg : shared widths, Q-format constants and FSM encoding for the
//           sns multiplier / divider pair.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sns_pkg;

   localparam int INT_W  = 7;
   localparam int FRAC_W = 8;
   localparam int PROD_W = 15;
   localparam int CNT_W  = 3;

   // Q0.8 weight: value = frac_val / 2**Q_FRAC_BITS; product is Q7.8
   localparam int Q_FRAC_BITS = FRAC_W;
   localparam int Q_INT_BITS  = INT_W;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MUL  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sns_multiplier.sv
// ============================================================================
// sns_multiplier : sequential shift-and-add multiply of a 7-bit integer by a
//                  Q0.8 fraction, giving Q7.8 product, floor and round.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sns_multiplier
   import sns_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INT_W-1:0]  int_val,
   input  logic [FRAC_W-1:0] frac_val,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] prod,
   output logic [INT_W-1:0]  int_floor,
   output logic [INT_W-1:0]  int_round
);

   state_t              r_state;
   state_t              w_next;
   logic [INT_W-1:0]    r_mcand;
   logic [FRAC_W-1:0]   r_mplier;
   logic [PROD_W-1:0]   r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic [PROD_W-1:0]   w_addend;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)            w_next = ST_MUL;
         ST_MUL:  if (r_cnt == 3'd7)       w_next = ST_DONE;
         ST_DONE: if (out_ready)           w_next = ST_IDLE;
         default:                          w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
   end

   // Partial product for the current multiplier bit weight 2**cnt
   assign w_addend = {{(PROD_W-INT_W){1'b0}}, r_mcand} << r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_mcand  <= int_val;
                  r_mplier <= frac_val;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            ST_MUL: begin
               if (r_mplier[0]) begin
                  r_acc <= r_acc + w_addend;
               end
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 3'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Max product 32385 keeps floor <= 126, so the rounding add cannot wrap
   assign prod      = r_acc;
   assign int_floor = r_acc[PROD_W-1:FRAC_W];
   assign int_round = r_acc[PROD_W-1:FRAC_W] + {{(INT_W-1){1'b0}}, r_acc[FRAC_W-1]};

endmodule

`default_nettype wire
